// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: pause bit map, FSM encoding
// and the instruction address width.
`ifndef InstAddrWidth
`define InstAddrWidth 32
`endif

package pipeline_ctrl_pkg;

  localparam int INST_ADDR_W = `InstAddrWidth;

  localparam int PAUSE_W   = 6;
  localparam int PAUSE_PC  = 0;
  localparam int PAUSE_IF  = 1;
  localparam int PAUSE_ID  = 2;
  localparam int PAUSE_EX  = 3;
  localparam int PAUSE_MEM = 4;
  localparam int PAUSE_WB  = 5;

  // Holding PC and IF makes IF/ID inject bubbles while fetch is redirected.
  localparam logic [PAUSE_W-1:0] REDIRECT_HOLD = 6'b000011;

  typedef enum logic {
    CTRL_RUN      = 1'b0,
    CTRL_REDIRECT = 1'b1
  } ctrl_state_e;

  // The deepest requesting stage freezes itself and everything upstream.
  function automatic logic [PAUSE_W-1:0] stall_vec(input logic req_if,
                                                   input logic req_id,
                                                   input logic req_ex,
                                                   input logic req_mem);
    logic [PAUSE_W-1:0] v;
    v = '0;
    if (req_mem)     v = 6'b011111;
    else if (req_ex) v = 6'b001111;
    else if (req_id) v = 6'b000111;
    else if (req_if) v = 6'b000011;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall-cycle and flush-cycle counters for the pipeline controller; free
// running, wrapping at 2^32, cleared by rst.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_cnt    <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: pause vector, branch/exception flushes and the
// fetch redirect handshake. Perf counters are built only with PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_W = INST_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause_req_if,
  input  logic               pause_req_id,
  input  logic               pause_req_ex,
  input  logic               pause_req_mem,
  input  logic               branch_req,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               excp_req,
  input  logic [PC_W-1:0]    excp_entry,
  input  logic               ertn_req,
  input  logic [PC_W-1:0]    era,
  input  logic               redirect_ready,
  output logic [PAUSE_W-1:0] pause,
  output logic               branch_flush,
  output logic               exception_flush,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               busy,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_cnt,
  output ctrl_state_e        dbg_state
);

  ctrl_state_e     state, state_next;
  logic [PC_W-1:0] pc_next;

  // Redirect handshake: redirect_valid stays high with redirect_pc stable
  // until a cycle with redirect_valid && redirect_ready; the transfer happens
  // at that clock edge. Exceptions/ERTN may replace the pc at any time.
  always_comb begin
    state_next      = state;
    pc_next         = redirect_pc;
    branch_flush    = 1'b0;
    exception_flush = 1'b0;
    pause = stall_vec(pause_req_if, pause_req_id, pause_req_ex, pause_req_mem);
    if (state == CTRL_REDIRECT) pause = pause | REDIRECT_HOLD;

    if (excp_req) begin
      exception_flush = 1'b1;
      pc_next         = excp_entry;
      state_next      = CTRL_REDIRECT;
    end else if (ertn_req) begin
      exception_flush = 1'b1;
      pc_next         = era;
      state_next      = CTRL_REDIRECT;
    end else if (branch_req && state == CTRL_RUN && !pause[PAUSE_EX]) begin
      branch_flush = 1'b1;
      pc_next      = branch_target;
      state_next   = CTRL_REDIRECT;
    end else if (state == CTRL_REDIRECT && redirect_ready) begin
      state_next = CTRL_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CTRL_RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      redirect_valid <= (state_next == CTRL_REDIRECT);
      redirect_pc    <= pc_next;
    end
  end

  assign busy      = (state != CTRL_RUN);
  assign dbg_state = state;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (pause[PAUSE_IF]),
    .flush        (branch_flush | exception_flush),
    .stall_cycles (perf_stall_cycles),
    .flush_cnt    (perf_flush_cnt)
  );
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a cycle-by-cycle vector table plus hand-written
// redirect corner sequences; registered outputs are checked via exp_q.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] BR_PC = 32'h1C00_0040;
  localparam logic [PC_W-1:0] EX_PC = 32'h1C00_8000;
  localparam logic [PC_W-1:0] ER_PC = 32'h1C00_0100;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause_req_if, pause_req_id, pause_req_ex, pause_req_mem;
  logic              branch_req, excp_req, ertn_req, redirect_ready;
  logic [PC_W-1:0]   branch_target, excp_entry, era;
  logic [5:0]        pause;
  logic              branch_flush, exception_flush, redirect_valid, busy;
  logic [PC_W-1:0]   redirect_pc;
  logic [31:0]       perf_stall_cycles, perf_flush_cnt;
  ctrl_state_e       dbg_state;

  pipeline_ctrl #(.PC_W(PC_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .pause_req_if      (pause_req_if),
    .pause_req_id      (pause_req_id),
    .pause_req_ex      (pause_req_ex),
    .pause_req_mem     (pause_req_mem),
    .branch_req        (branch_req),
    .branch_target     (branch_target),
    .excp_req          (excp_req),
    .excp_entry        (excp_entry),
    .ertn_req          (ertn_req),
    .era               (era),
    .redirect_ready    (redirect_ready),
    .pause             (pause),
    .branch_flush      (branch_flush),
    .exception_flush   (exception_flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .busy              (busy),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic            rst, pif, pid, pex, pmem, br, ex, er, rdy;
    logic [5:0]      pause;
    logic            bf, ef, rv, busy;
    logic [PC_W-1:0] pc;
  } vec_t;

  localparam int N_VEC = 23;
  vec_t vecs[N_VEC];

  // ---------------- scoreboard ----------------
  logic [PC_W+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_vec(input int i,
                         input logic r, input logic pif, input logic pid,
                         input logic pex, input logic pmem, input logic br,
                         input logic ex, input logic er, input logic rdy,
                         input logic [5:0] p, input logic bf, input logic ef,
                         input logic rv, input logic bsy, input logic [PC_W-1:0] pc);
    vecs[i].rst = r;   vecs[i].pif = pif; vecs[i].pid = pid; vecs[i].pex = pex;
    vecs[i].pmem = pmem; vecs[i].br = br; vecs[i].ex = ex;  vecs[i].er = er;
    vecs[i].rdy = rdy; vecs[i].pause = p; vecs[i].bf = bf;  vecs[i].ef = ef;
    vecs[i].rv = rv;   vecs[i].busy = bsy; vecs[i].pc = pc;
  endtask

  // Drive one cycle: combinational outputs checked before the edge, registered
  // outputs queued now and compared after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [PC_W+1:0] e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    rst = v.rst; pause_req_if = v.pif; pause_req_id = v.pid;
    pause_req_ex = v.pex; pause_req_mem = v.pmem; branch_req = v.br;
    excp_req = v.ex; ertn_req = v.er; redirect_ready = v.rdy;
    #1;
    check({tag, " pause"}, 64'(pause), 64'(v.pause));
    check({tag, " branch_flush"}, 64'(branch_flush), 64'(v.bf));
    check({tag, " exception_flush"}, 64'(exception_flush), 64'(v.ef));
    exp_q.push_back({v.rv, v.busy, v.pc});
`ifdef PIPE_CTRL_PERF_EN
    if (v.rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (v.pause[1]) exp_stall = exp_stall + 32'd1;
      if (v.bf || v.ef) exp_flush = exp_flush + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " redirect_valid"}, 64'(redirect_valid), 64'(e[PC_W+1]));
    check({tag, " busy"}, 64'(busy), 64'(e[PC_W]));
    check({tag, " state"}, 64'(dbg_state), 64'(e[PC_W]));
    check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(e[PC_W-1:0]));
    check({tag, " perf_stall"}, 64'(perf_stall_cycles), 64'(exp_stall));
    check({tag, " perf_flush"}, 64'(perf_flush_cnt), 64'(exp_flush));
  endtask

  initial begin
    vec_t h;
    rst = 1'b1;
    pause_req_if = 0; pause_req_id = 0; pause_req_ex = 0; pause_req_mem = 0;
    branch_req = 0; excp_req = 0; ertn_req = 0; redirect_ready = 0;
    branch_target = BR_PC; excp_entry = EX_PC; era = ER_PC;

    //          r pif pid pex mem br ex er rdy  pause     bf ef rv busy pc
    set_vec( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, '0);
    set_vec( 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, '0);
    set_vec( 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0, 0, '0);
    set_vec( 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0, '0);
    set_vec( 4, 0, 1, 0, 0, 1, 0, 0, 0, 0, 6'b011111, 0, 0, 0, 0, '0);
    set_vec( 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 0, '0);
    set_vec( 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6'b011111, 0, 0, 0, 0, '0);
    set_vec( 7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, 0, '0);
    set_vec( 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 1, 0, 1, 1, BR_PC);
    set_vec( 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0, 0, 1, 1, BR_PC);
    set_vec(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 1, 1, BR_PC);
    set_vec(11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 0, 0, 0, 0, BR_PC);
    set_vec(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, BR_PC);
    set_vec(13, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b000000, 0, 1, 1, 1, EX_PC);
    set_vec(14, 0, 0, 1, 0, 0, 0, 0, 0, 1, 6'b000111, 0, 0, 0, 0, EX_PC);
    set_vec(15, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 1, 0, 1, 1, BR_PC);
    set_vec(16, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011, 0, 1, 1, 1, ER_PC);
    set_vec(17, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b000011, 0, 1, 1, 1, EX_PC);
    set_vec(18, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 1, EX_PC);
    set_vec(19, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0, 0, '0);
    set_vec(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, '0);
    set_vec(21, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 1, 1, 1, ER_PC);
    set_vec(22, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 0, 0, 0, 0, ER_PC);

    repeat (2) @(posedge clk);
    for (int i = 0; i < N_VEC; i++) apply(vecs[i], i);

    // Minimum occupancy: ready already high when the branch is taken.
    h = vecs[20];
    h.br = 1; h.rdy = 1; h.bf = 1; h.rv = 1; h.busy = 1; h.pc = BR_PC;
    apply(h, 100);
    h = vecs[20];
    h.rdy = 1; h.pause = 6'b000011; h.pc = BR_PC;
    apply(h, 101);

    // Three EX stall cycles, then a randomly timed handshake after an exception.
    h = vecs[1];
    h.pc = BR_PC;
    for (int i = 0; i < 3; i++) apply(h, 102 + i);
    h = vecs[20];
    h.ex = 1; h.ef = 1; h.rv = 1; h.busy = 1; h.pc = EX_PC;
    apply(h, 105);
    begin
      int wait_cycles;
      wait_cycles = $urandom_range(0, 4);
      h = vecs[20];
      h.pause = 6'b000011; h.rv = 1; h.busy = 1; h.pc = EX_PC;
      for (int i = 0; i < wait_cycles; i++) apply(h, 106 + i);
      h.rdy = 1; h.rv = 0; h.busy = 0;
      apply(h, 110);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the LoongArch core. It merges per-stage stall requests into the 6-bit `pause` vector consumed by every pipeline register, and raises `branch_flush` and `exception_flush`. It also sequences the PC redirect handshake with the fetch stage after a taken branch, an exception or an ERTN. It sits beside the PC/IF/ID/EX/MEM/WB chain and is the only source of those control signals.

## Interface
- `PC_W`, default 32: width of redirect addresses.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `pause_req_if` / `pause_req_id` / `pause_req_ex` / `pause_req_mem` input 1 each: stall request from that stage.
- `branch_req` input 1: taken branch/jump resolved in EX.
- `branch_target` input PC_W: branch destination.
- `excp_req` input 1: exception committed at MEM/WB.
- `excp_entry` input PC_W: exception entry address (EENTRY).
- `ertn_req` input 1: ERTN committed.
- `era` input PC_W: return address for ERTN.
- `redirect_ready` input 1: fetch stage accepts the redirect.
- `pause` output 6: bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `branch_flush` output 1: kill IF/ID and ID/EX contents.
- `exception_flush` output 1: kill all pipeline registers.
- `redirect_valid` output 1: registered.
- `redirect_pc` output PC_W: registered.
- `busy` output 1: high while not in RUN.
- `perf_stall_cycles` output 32 and `perf_flush_cnt` output 32: see Configuration.

## Operation
- FSM states are RUN and REDIRECT.
- Stall vector: the highest requesting stage k sets `pause[k:0]` to all ones.
  - if → 6'b000011
  - id → 6'b000111
  - ex → 6'b001111
  - mem → 6'b011111
  - With no request, `pause` is 0.
- In REDIRECT, `pause` is the stall vector OR 6'b000011. PC and IF are held, so IF/ID injects bubbles.
- Priority within a cycle: excp_req > ertn_req > branch_req > stall.
- Exception or ERTN, in any state:
  - `exception_flush` is 1 combinationally in that cycle.
  - `redirect_pc` is loaded with `excp_entry` or `era`.
  - The FSM enters REDIRECT.
  - Any pending branch redirect is overwritten.
- Branch, RUN state only:
  - Accepted only when `pause[3]` is 0, i.e. EX is not stalled. Otherwise it is ignored, and EX re-presents it.
  - When accepted, `branch_flush` is 1 combinationally, `redirect_pc` is loaded with `branch_target`, and the FSM enters REDIRECT.
- `branch_req` arriving in REDIRECT is ignored.
- REDIRECT:
  - `redirect_valid` = 1 and `redirect_pc` stays stable until `redirect_valid && redirect_ready`.
  - On that handshake the next state is RUN and `redirect_valid` drops.
  - A new exception in the handshake cycle wins: the FSM stays in REDIRECT with the new pc.
- `pause_req_*` never blocks a flush. Flush outputs are independent of `pause`.

## Timing
- Reset values: state RUN, `pause` 0, `branch_flush` 0, `exception_flush` 0, `redirect_valid` 0, `redirect_pc` 0, `busy` 0, counters 0.
- `pause`, `branch_flush` and `exception_flush` are combinational from inputs and state, with zero latency.
- Request seen at cycle T → `redirect_valid` at T+1.
- Handshake at cycle H → `redirect_valid` = 0 and RUN state at H+1.
- Minimum redirect occupancy is one cycle.
- `rst` asserted mid-REDIRECT drops `redirect_valid` the next cycle. No redirect survives reset.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` increments on every cycle with `pause[1]` set.
  - `perf_flush_cnt` increments on every cycle with `branch_flush` or `exception_flush` set.
  - Both wrap at 2^32 and clear on `rst`.
- Without the macro, both ports are present but tied to 0, and no counter flops are built.

## Structure
- Shared package / `define.v` holds:
  - the pause bit indices (PAUSE_PC … PAUSE_WB),
  - the FSM state encoding (CTRL_RUN = 1'b0, CTRL_REDIRECT = 1'b1),
  - the PC width macro `InstAddrWidth`.
- Sub-module `pipe_ctrl_perf` holds the two counters, instantiated under `PIPE_CTRL_PERF_EN`.

## Test plan
- `pause_req_ex` = 1 only → `pause` = 6'b001111, no flush, state RUN.
- `branch_req` with `branch_target` = 0x1C000040 and `redirect_ready` held 0 for 3 cycles:
  - `branch_flush` pulses 1 cycle.
  - `redirect_valid` is high with pc 0x1C000040 for 3 cycles, then drops after the ready cycle.
  - `pause` = 6'b000011 throughout.
- `branch_req` together with `pause_req_mem` → no flush, `pause` = 6'b011111, state RUN.
- `excp_req` (`excp_entry` = 0x1C008000) and `branch_req` in the same cycle → only `exception_flush` asserts, `redirect_pc` = 0x1C008000.
- Branch redirect pending, then `ertn_req` with `era` = 0x1C000100 → `exception_flush` pulses, `redirect_pc` becomes 0x1C000100 the next cycle, `redirect_valid` stays high.
- `rst` pulsed while in REDIRECT → the next cycle shows all outputs 0 and state RUN. With `PIPE_CTRL_PERF_EN`, counters read 0 after reset and count 3 after 3 stalled cycles.
